d16_dbus_arb: RTL

Data-bus arbiter between the d16 core data port and one secondary burst master (debug loader / DMA). It shares the single synchronous data RAM.
- Core has fixed priority and is never delayed.
- Secondary master is served one word per cycle in core-idle slots.
- Sits between d16_top data bus and the RAM; RAM keeps its 1-cycle registered read.

---
 rtl/d16_dbus_arb_pkg.sv | 26 ++
 rtl/d16_dbus_arb_cpt16.sv | 22 ++
 rtl/d16_dbus_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/d16_dbus_arb_pkg.sv
// Shared types and helpers for the d16 data-bus arbiter.
// Arbiter state encoding, burst length width and burst-length normalisation.
package d16_dbus_arb_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // A zero length still moves one word; anything past the cap is clipped.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                                input int max_burst);
    logic [LEN_W-1:0] cap;
    cap = LEN_W'(max_burst);
    if (len == '0)
      return LEN_W'(1);
    else if (len > cap)
      return cap;
    else
      return len;
  endfunction

endpackage

// File: rtl/d16_dbus_arb_cpt16.sv
// 16-bit loadable up/down counter used as the burst address pointer.
// Wraps naturally at the ends of the 16-bit range.
module d16_dbus_arb_cpt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        dir,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= din;
    else if (en)
      q <= dir ? q + 16'd1 : q - 16'd1;
  end

endmodule

// File: rtl/d16_dbus_arb.sv
// d16 data-bus arbiter: core has fixed priority, a secondary burst master
// fills core-idle slots. Optional macro D16_DBUS_ARB_STALL_EN adds core_stall.
//
// state    | meaning
// ST_IDLE  | waiting for m_req; burst parameters latched on acceptance
// ST_BURST | one secondary word issued per cycle the core leaves free
// ST_DRAIN | single cycle: m_done pulse, last read word returns
module d16_dbus_arb
  import d16_dbus_arb_pkg::*;
#(
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] core_a,
  input  logic [15:0] core_do,
  input  logic        core_we,
  input  logic        core_re,
  output logic [15:0] core_di,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [15:0] m_a,
  input  logic [4:0]  m_len,
  input  logic [15:0] m_do,
  output logic        m_wnext,
  output logic [15:0] m_di,
  output logic        m_rvalid,
  output logic        m_busy,
  output logic        m_done,
  output logic        starve,
  output logic [15:0] mem_a,
  output logic [15:0] mem_do,
  output logic        mem_we,
  input  logic [15:0] mem_di
`ifdef D16_DBUS_ARB_STALL_EN
  ,
  output logic        core_stall
`endif
);

  arb_state_t       state, state_nxt;
  logic             dir_q;
  logic [LEN_W-1:0] rem_q;
  logic [15:0]      addr_q;
  logic [15:0]      starve_cnt;
  logic             rvalid_q;
  logic             core_act;
  logic             issue;
  logic             accept;
  logic             last;

  assign core_act = core_re | core_we;
  assign issue    = (state == ST_BURST) && !core_act;
  assign accept   = (state == ST_IDLE) && m_req;
  assign last     = (rem_q == '0);

  d16_dbus_arb_cpt16 u_addr (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .dir  (1'b1),
    .load (accept),
    .en   (issue),
    .din  (m_a),
    .q    (addr_q)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (m_req) state_nxt = ST_BURST;
      ST_BURST: if (issue && last) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // rem_q counts down the words still to issue after the current one.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dir_q    <= 1'b0;
      rem_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= issue && !dir_q;
      if (accept) begin
        dir_q <= m_we;
        rem_q <= eff_len(m_len, MAX_BURST) - LEN_W'(1);
      end else if (issue && !last) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      starve_cnt <= '0;
    else if (state != ST_BURST || issue)
      starve_cnt <= '0;
    else if (core_act && starve_cnt != 16'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 16'd1;
  end

  assign starve   = (starve_cnt == 16'(STARVE_LIMIT));

  assign mem_a    = issue ? addr_q : core_a;
  assign mem_do   = (issue && dir_q) ? m_do : core_do;
  assign mem_we   = core_we | (issue & dir_q);
  assign m_wnext  = issue & dir_q;
  assign m_rvalid = rvalid_q;
  assign m_di     = rvalid_q ? mem_di : 16'h0000;
  assign core_di  = mem_di;
  assign m_busy   = (state == ST_BURST);
  assign m_done   = (state == ST_DRAIN);

`ifdef D16_DBUS_ARB_STALL_EN
  assign core_stall = starve;
`endif

endmodule
